// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream, instruction-memory write and status signals of the loader
interface imem_loader_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic [1:0]        err;
  logic [ADDR_W:0]   word_cnt;

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err, word_cnt
  );

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err, word_cnt
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads length-prefixed, XOR-checksummed little-endian words into instruction memory
// Stream format: length byte, 4*length data bytes, checksum byte (XOR of all data bytes).
module imem_loader #(
  parameter int ADDR_W    = 4,
  parameter int MAX_WORDS = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  imem_loader_if.slave     bus
);
  localparam int         CNT_W   = ADDR_W + 1;
  localparam logic [8:0] MAX_LEN = 9'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;

  logic ready, we, hold;
  logic accept, len_bad, last_word, csum_ok, session_start;

  assign accept        = bus.byte_valid && ready;
  assign len_bad       = (bus.byte_data == 8'd0) || ({1'b0, bus.byte_data} > MAX_LEN);
  assign last_word     = (cnt_q + CNT_W'(1)) == len_q;
  assign csum_ok       = bus.byte_data == csum_q;
  assign session_start = bus.start &&
                         (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (bus.start) state_d = S_LEN;
      S_LEN:   if (accept) state_d = len_bad ? S_ERR : S_DATA;
      S_DATA:  if (accept && idx_q == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_CSUM : S_DATA;
      S_CSUM:  if (accept) state_d = csum_ok ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    we    = 1'b0;
    hold  = 1'b1;
    case (state_q)
      S_LEN, S_DATA, S_CSUM: ready = 1'b1;
      S_WRITE:               we    = 1'b1;
      S_IDLE, S_DONE:        hold  = 1'b0;
      default:               ;
    endcase
  end

  // Write address is captured with byte 3 so it always names the word being written, never len.
  always_comb begin
    cnt_d   = cnt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    done_d  = done_q;
    err_d   = err_q;
    if (session_start) begin
      cnt_d  = '0;
      idx_d  = '0;
      csum_d = '0;
      done_d = 1'b0;
      err_d  = 2'b00;
    end
    case (state_q)
      S_LEN: if (accept) begin
        if (len_bad) err_d = 2'b01;
        else         len_d = CNT_W'(bus.byte_data);
      end
      S_DATA: if (accept) begin
        wdata_d[{idx_q, 3'b000} +: 8] = bus.byte_data;
        csum_d = csum_q ^ bus.byte_data;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'd3) waddr_d = cnt_q[ADDR_W-1:0];
      end
      S_WRITE: begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = '0;
      end
      S_CSUM: if (accept) begin
        if (csum_ok) done_d = 1'b1;
        else         err_d  = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready = ready;
  assign bus.im_we      = we;
  assign bus.im_waddr   = waddr_q;
  assign bus.im_wdata   = wdata_q;
  assign bus.cpu_hold   = hold;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.word_cnt   = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk;
  logic rstn;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   ready_in_write = 0;
  logic [35:0] wlog[$];

  imem_loader_if #(.ADDR_W(4)) bus ();

  imem_loader #(.ADDR_W(4), .MAX_WORDS(16)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.im_we) wlog.push_back({bus.im_waddr, bus.im_wdata});
    if (bus.im_we && bus.byte_ready) ready_in_write++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.byte_ready, 1'b0);
    check({tag, "_we"},    bus.im_we,      1'b0);
    check({tag, "_waddr"}, bus.im_waddr,   4'h0);
    check({tag, "_wdata"}, bus.im_wdata,   32'h0);
    check({tag, "_hold"},  bus.cpu_hold,   1'b0);
    check({tag, "_done"},  bus.done,       1'b0);
    check({tag, "_err"},   bus.err,        2'b00);
    check({tag, "_cnt"},   bus.word_cnt,   5'd0);
  endtask

  // Called and returns on a falling edge; the byte is taken on the rising edge in between.
  task automatic send_byte(input logic [7:0] b, input int gmax);
    int n = 0;
    if (gmax > 0) repeat ($urandom_range(0, gmax)) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("byte_timeout", n < 40, 1'b1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] a, input logic [31:0] w, input int gmax);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gmax);
    check("write_we",    bus.im_we,      1'b1);
    check("write_addr",  bus.im_waddr,   a);
    check("write_data",  bus.im_wdata,   w);
    check("write_ready", bus.byte_ready, 1'b0);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("len_hold",  bus.cpu_hold,   1'b1);
    check("len_ready", bus.byte_ready, 1'b1);
  endtask

  task automatic check_log(input int n);
    logic [35:0] e0, e1;
    e0 = (wlog.size() > 0) ? wlog[0] : '1;
    e1 = (wlog.size() > 1) ? wlog[1] : '1;
    check("log_size", wlog.size(), n);
    if (n >= 1) check("log_word0", e0, {4'h0, 32'h0000_0013});
    if (n >= 2) check("log_word1", e1, {4'h1, 32'h0050_0093});
  endtask

  // Two-word program 00000013, 00500093; XOR of its eight data bytes is D0.
  task automatic run_stream(input logic [7:0] csum, input int gmax);
    wlog.delete();
    do_start();
    send_byte(8'h02, gmax);
    send_word(4'h0, 32'h0000_0013, gmax);
    send_word(4'h1, 32'h0050_0093, gmax);
    send_byte(csum, gmax);
  endtask

  initial begin
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rstn = 1'b1;
    @(negedge clk);

    run_stream(8'hD0, 0);
    check("good_done", bus.done,     1'b1);
    check("good_err",  bus.err,      2'b00);
    check("good_hold", bus.cpu_hold, 1'b0);
    check("good_cnt",  bus.word_cnt, 5'd2);
    check_log(2);

    wlog.delete();
    do_start();
    send_byte(8'h00, 0);
    check("len0_err",  bus.err,      2'b01);
    check("len0_hold", bus.cpu_hold, 1'b1);
    check("len0_done", bus.done,     1'b0);
    do_start();
    send_byte(8'h11, 0);
    check("len17_err",  bus.err,      2'b01);
    check("len17_hold", bus.cpu_hold, 1'b1);
    check_log(0);
    do_start();
    send_byte(8'h10, 0);
    check("len16_err",   bus.err,        2'b00);
    check("len16_ready", bus.byte_ready, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    run_stream(8'h00, 0);
    check("bad_err",  bus.err,      2'b10);
    check("bad_done", bus.done,     1'b0);
    check("bad_hold", bus.cpu_hold, 1'b1);
    check_log(2);
    run_stream(8'hD0, 0);
    check("retry_done", bus.done, 1'b1);
    check("retry_err",  bus.err,  2'b00);

    run_stream(8'hD0, 5);
    check("gap_done", bus.done,     1'b1);
    check("gap_err",  bus.err,      2'b00);
    check("gap_hold", bus.cpu_hold, 1'b0);
    check_log(2);

    wlog.delete();
    do_start();
    send_byte(8'h02, 0);
    send_word(4'h0, 32'h0000_0013, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h50;
    #2 rstn = 1'b0;
    #1 check_reset_outputs("async");
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_log", wlog.size(), 1);
    check("abort_hold", bus.cpu_hold, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    run_stream(8'hD0, 0);
    check("after_rst_done", bus.done, 1'b1);
    check_log(2);

    wlog.delete();
    do_start();
    send_byte(8'h02, 0);
    bus.start = 1'b1;
    send_word(4'h0, 32'h0000_0013, 0);
    bus.start = 1'b0;
    send_word(4'h1, 32'h0050_0093, 0);
    send_byte(8'hD0, 0);
    check("restart_done", bus.done,     1'b1);
    check("restart_err",  bus.err,      2'b00);
    check("restart_cnt",  bus.word_cnt, 5'd2);
    check_log(2);

    check("ready_in_write", ready_in_write, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
